// File: rtl/tlp_xcvr_pkg.sv
// Shared types and helpers for the TLP transmit path.
// Provides the uint64/uint32 beat and counter types, the arbiter state
// enum and the round-robin pointer increment used by tlp_tx_arb.
package tlp_xcvr_pkg;

   typedef logic [63:0] uint64;
   typedef logic [31:0] uint32;

   // Arbiter lock state: S_IDLE arbitrates on SOP, S_PKT is locked to one source.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } ArbState;

   // Next round-robin position, wrapping at n (n need not be a power of two).
   function automatic int rrNext(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/tlp_arb_rr_pick.sv
// Round-robin picker for the TLP TX arbiter (purely combinational).
// Finds the first asserted request at or after rrPtr, searching cyclically.
// The request vector is doubled so the cyclic search becomes a plain
// lowest-bit priority encode over bits at or above rrPtr.
module tlp_arb_rr_pick
   import tlp_xcvr_pkg::*;
#(
   parameter  int NUM_SRC = 3,
   localparam int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   rrPtr,
   output logic [SRC_W-1:0]   pick,
   output logic               anyReq
);

   logic [2*NUM_SRC-1:0] reqDbl;
   logic                 found;

   // Masked priority encode over the doubled request vector.
   always_comb begin
      reqDbl = {req, req};
      found  = 1'b0;
      pick   = '0;
      for (int i = 0; i < 2 * NUM_SRC; i++) begin
         if (!found && (i >= int'(rrPtr)) && reqDbl[i]) begin
            found = 1'b1;
            pick  = SRC_W'((i >= NUM_SRC) ? (i - NUM_SRC) : i);
         end
      end
      anyReq = |req;
   end

endmodule

// File: rtl/tlp_tx_arb.sv
// Packet-granular round-robin arbiter in front of the PCIe core TX port.
// A whole packet (SOP..EOP) is granted to one source; beats are forwarded
// combinationally so the arbiter adds no latency.
// Optional per-source completed-packet counters: define TLP_ARB_STATS_EN.
//
// Handshake: a beat moves when txValid_out & txReady_in. txValid_out is only
// raised while txReady_in=1, so txValid_out itself marks an accepted beat, and
// srcReady_out[i] is high exactly when source i's beat is the one accepted.
module tlp_tx_arb
   import tlp_xcvr_pkg::*;
#(
   parameter  int NUM_SRC = 3,
   localparam int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                      pcieClk_in,
   input  logic                      pcieRstN_in,
   input  logic [NUM_SRC-1:0][63:0]  srcData_in,
   input  logic [NUM_SRC-1:0]        srcValid_in,
   input  logic [NUM_SRC-1:0]        srcSOP_in,
   input  logic [NUM_SRC-1:0]        srcEOP_in,
   output logic [NUM_SRC-1:0]        srcReady_out,
   output logic [63:0]               txData_out,
   output logic                      txValid_out,
   input  logic                      txReady_in,
   output logic                      txSOP_out,
   output logic                      txEOP_out,
   output logic [SRC_W-1:0]          grantIdx_out,
   output logic                      busy_out,
   output logic                      errProto_out,
   input  logic                      statsClear_in,
   output logic [NUM_SRC-1:0][31:0]  statsCount_out,
   output ArbState                   arbState_out,
   output logic [SRC_W-1:0]          rrPtr_out
);

   ArbState            stateQ, stateD;
   logic [SRC_W-1:0]   rrPtrQ, rrPtrD;
   logic [SRC_W-1:0]   grantQ, grantD;
   logic               errQ, errD;
   logic [SRC_W-1:0]   fwdIdx;
   logic [SRC_W-1:0]   pickIdx;
   logic               anyReq;
   logic               fwdLegal;
   logic               accepted;
   logic [NUM_SRC-1:0] sopReq;

   // Only a beat carrying SOP may open a new packet.
   assign sopReq = srcValid_in & srcSOP_in;

   tlp_arb_rr_pick #(
      .NUM_SRC (NUM_SRC)
   ) uPick (
      .req    (sopReq),
      .rrPtr  (rrPtrQ),
      .pick   (pickIdx),
      .anyReq (anyReq)
   );

   // Next-state logic: choose the forwarded source, track lock, pointer and protocol errors.
   always_comb begin
      stateD   = stateQ;
      rrPtrD   = rrPtrQ;
      grantD   = grantQ;
      errD     = errQ;
      fwdIdx   = grantQ;
      fwdLegal = 1'b0;
      case (stateQ)
         S_IDLE: begin
            fwdIdx   = pickIdx;
            fwdLegal = anyReq;
            // A beat without SOP while unlocked is never accepted and is flagged.
            if (|(srcValid_in & ~srcSOP_in)) begin
               errD = 1'b1;
            end
         end
         S_PKT: begin
            fwdLegal = srcValid_in[grantQ];
            // A fresh SOP inside a packet is passed through but flagged.
            if (srcValid_in[grantQ] && srcSOP_in[grantQ]) begin
               errD = 1'b1;
            end
         end
         default: begin
            stateD = S_IDLE;
         end
      endcase
      accepted = fwdLegal & txReady_in;
      if (accepted) begin
         grantD = fwdIdx;
         if (srcEOP_in[fwdIdx]) begin
            stateD = S_IDLE;
            rrPtrD = SRC_W'(rrNext(int'(fwdIdx), NUM_SRC));
         end else begin
            stateD = S_PKT;
         end
      end
   end

   // Per-source ready: only the accepted source sees ready.
   always_comb begin
      srcReady_out = '0;
      if (accepted) begin
         srcReady_out[fwdIdx] = 1'b1;
      end
   end

   assign txValid_out  = accepted;
   assign txData_out   = srcData_in[fwdIdx];
   assign txSOP_out    = accepted & srcSOP_in[fwdIdx];
   assign txEOP_out    = accepted & srcEOP_in[fwdIdx];
   assign grantIdx_out = grantQ;
   assign busy_out     = (stateQ == S_PKT);
   assign errProto_out = errQ;
   assign arbState_out = stateQ;
   assign rrPtr_out    = rrPtrQ;

   // State, pointer, grant and sticky error registers; reset drops any lock at once.
   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         stateQ <= S_IDLE;
         rrPtrQ <= '0;
         grantQ <= '0;
         errQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         rrPtrQ <= rrPtrD;
         grantQ <= grantD;
         errQ   <= errD;
      end
   end

`ifdef TLP_ARB_STATS_EN
   logic [NUM_SRC-1:0][31:0] cntQ;

   // Completed-packet counters; a clear in the same cycle as an EOP wins.
   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         cntQ <= '0;
      end else if (statsClear_in) begin
         cntQ <= '0;
      end else if (accepted && srcEOP_in[fwdIdx]) begin
         cntQ[fwdIdx] <= cntQ[fwdIdx] + 32'd1;
      end
   end

   assign statsCount_out = cntQ;
`else
   logic unusedStatsClear;

   assign unusedStatsClear = statsClear_in;
   assign statsCount_out   = '0;
`endif

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Testbench for tlp_tx_arb (NUM_SRC=3).
// Drivers issue packets and push the expected beats into exp_q; a monitor on
// the falling edge predicts each cycle's forwarding from the arbitration rules
// and pops/compares the forwarded beat. Counter checks follow TLP_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_tlp_tx_arb;
   import tlp_xcvr_pkg::*;

   localparam int N = 3;
`ifdef TLP_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int          src;
      logic [63:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   logic               clk;
   logic               rstN;
   logic [N-1:0][63:0] srcData;
   logic [N-1:0]       srcValid, srcSOP, srcEOP, srcReady;
   logic [63:0]        txData;
   logic               txValid, txReady, txSOP, txEOP;
   logic [1:0]         grantIdx;
   logic               busy, errProto, statsClear;
   logic [N-1:0][31:0] statsCount;
   ArbState            arbState;
   logic [1:0]         rrPtr;

   beat_t       exp_q[$];
   int          sopLog[$];
   int          nChecks = 0;
   int          nFail = 0;

   // reference model state
   bit          mLocked;
   int          mOwner, mPtr, mGrant;
   bit          mErr;
   int unsigned mCnt[N];

   tlp_tx_arb #(.NUM_SRC(N)) dut (
      .pcieClk_in     (clk),
      .pcieRstN_in    (rstN),
      .srcData_in     (srcData),
      .srcValid_in    (srcValid),
      .srcSOP_in      (srcSOP),
      .srcEOP_in      (srcEOP),
      .srcReady_out   (srcReady),
      .txData_out     (txData),
      .txValid_out    (txValid),
      .txReady_in     (txReady),
      .txSOP_out      (txSOP),
      .txEOP_out      (txEOP),
      .grantIdx_out   (grantIdx),
      .busy_out       (busy),
      .errProto_out   (errProto),
      .statsClear_in  (statsClear),
      .statsCount_out (statsCount),
      .arbState_out   (arbState),
      .rrPtr_out      (rrPtr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int expCnt(input int n);
      return STATS ? n : 0;
   endfunction

   task automatic idle_inputs();
      srcValid = '0;
      srcSOP   = '0;
      srcEOP   = '0;
      srcData  = '0;
   endtask

   task automatic apply_reset();
      rstN       = 1'b0;
      idle_inputs();
      txReady    = 1'b0;
      statsClear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
   endtask

   task automatic push_beat(input int src, input logic [63:0] data, input logic sop, input logic eop);
      beat_t b;
      b.src  = src;
      b.data = data;
      b.sop  = sop;
      b.eop  = eop;
      exp_q.push_back(b);
   endtask

   // monitor: predict this cycle from the rules, compare, then advance the model
   task automatic monitor_cycle();
      logic [N-1:0] v, s, e;
      bit           rdy, found, expValid, newErr;
      int           src, idx, hit;
      v   = srcValid;
      s   = srcSOP;
      e   = srcEOP;
      rdy = txReady;
      check("busy", busy, mLocked);
      check("state_locked", arbState == S_PKT, mLocked);
      check("grant_idx", grantIdx, mGrant);
      check("rr_ptr", rrPtr, mPtr);
      check("err_proto", errProto, mErr);
      for (int i = 0; i < N; i++) begin
         check($sformatf("stats_count%0d", i), statsCount[i], expCnt(int'(mCnt[i])));
      end
      newErr = mErr;
      found  = 1'b0;
      src    = 0;
      if (!mLocked) begin
         for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (!found && v[idx] && s[idx]) begin
               found = 1'b1;
               src   = idx;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (v[i] && !s[i]) newErr = 1'b1;
         end
         expValid = found && rdy;
      end else begin
         src      = mOwner;
         expValid = rdy && v[src];
         if (v[src] && s[src]) newErr = 1'b1;
      end
      check("tx_valid", txValid, expValid);
      check("src_ready", srcReady, expValid ? (64'd1 << src) : 64'd0);
      if (!expValid) begin
         check("tx_sop_quiet", txSOP, 0);
         check("tx_eop_quiet", txEOP, 0);
      end else begin
         hit = -1;
         for (int j = 0; j < exp_q.size(); j++) begin
            if (hit < 0 && exp_q[j].src == src) hit = j;
         end
         if (hit < 0) begin
            nChecks++;
            nFail++;
            $display("FAIL exp_present: beat from src %0d forwarded, none expected at %0t", src, $time);
         end else begin
            check("tx_data", txData, exp_q[hit].data);
            check("tx_sop", txSOP, exp_q[hit].sop);
            check("tx_eop", txEOP, exp_q[hit].eop);
            exp_q.delete(hit);
         end
         if (!mLocked) sopLog.push_back(src);
         mGrant = src;
         if (e[src]) begin
            mLocked = 1'b0;
            mPtr    = (src + 1) % N;
            mCnt[src]++;
         end else begin
            mLocked = 1'b1;
            mOwner  = src;
         end
      end
      if (statsClear) begin
         for (int i = 0; i < N; i++) mCnt[i] = 0;
      end
      mErr = newErr;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rstN) begin
            mLocked = 1'b0;
            mOwner  = 0;
            mPtr    = 0;
            mGrant  = 0;
            mErr    = 1'b0;
            for (int i = 0; i < N; i++) mCnt[i] = 0;
            exp_q.delete();
         end else begin
            monitor_cycle();
         end
      end
   end

   // driver: random packets per source, with quotas, random gaps and txReady
   task automatic drive_pkts(input int n0, input int n1, input int n2, input int minLen,
                             input int maxLen, input int readyPct, input int gapPct);
      int          quota[N];
      int          len[N];
      int          pos[N];
      bit          active[N];
      logic [63:0] pkt[N][8];
      logic [N-1:0] acc;
      int          cyc;
      bit          done;
      quota[0] = n0;
      quota[1] = n1;
      quota[2] = n2;
      for (int i = 0; i < N; i++) begin
         active[i] = 1'b0;
         len[i]    = 0;
         pos[i]    = 0;
      end
      cyc = 0;
      while (1) begin
         done = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (active[i] || quota[i] > 0) done = 1'b0;
         end
         if (done) break;
         if (cyc > 3000) begin
            nChecks++;
            nFail++;
            $display("FAIL drive_timeout: packets still pending after %0d cycles", cyc);
            break;
         end
         for (int i = 0; i < N; i++) begin
            if (!active[i] && quota[i] > 0 && $urandom_range(99) >= gapPct) begin
               len[i]    = $urandom_range(maxLen, minLen);
               pos[i]    = 0;
               active[i] = 1'b1;
               quota[i]--;
               for (int b = 0; b < len[i]; b++) begin
                  pkt[i][b] = {$urandom, $urandom};
                  push_beat(i, pkt[i][b], b == 0, b == len[i] - 1);
               end
            end
            if (active[i] && (pos[i] == 0 || $urandom_range(99) >= gapPct)) begin
               srcValid[i] = 1'b1;
               srcSOP[i]   = (pos[i] == 0);
               srcEOP[i]   = (pos[i] == len[i] - 1);
               srcData[i]  = pkt[i][pos[i]];
            end else begin
               srcValid[i] = 1'b0;
               srcSOP[i]   = 1'b0;
               srcEOP[i]   = 1'b0;
               srcData[i]  = '0;
            end
         end
         txReady = ($urandom_range(99) < readyPct);
         @(negedge clk);
         acc = srcReady;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               pos[i]++;
               if (pos[i] == len[i]) active[i] = 1'b0;
            end
         end
         cyc++;
      end
      idle_inputs();
      txReady = 1'b0;
   endtask

   // single-beat packet (SOP=EOP=1) from one source, optionally with a counter clear
   task automatic one_beat(input int src, input bit clr);
      logic [63:0] d;
      d            = {$urandom, $urandom};
      srcData[src] = d;
      srcValid[src] = 1'b1;
      srcSOP[src]  = 1'b1;
      srcEOP[src]  = 1'b1;
      statsClear   = clr;
      txReady      = 1'b1;
      push_beat(src, d, 1'b1, 1'b1);
      @(negedge clk);
      check("single_accept", srcReady[src], 1);
      check("single_not_locked", arbState == S_PKT, 0);
      @(posedge clk);
      #1;
      idle_inputs();
      statsClear = 1'b0;
   endtask

   // stimulus
   initial begin
      int          expOrder[6];
      logic [63:0] d[4];
      int          pos;
      bit          acc;

      idle_inputs();
      txReady    = 1'b0;
      statsClear = 1'b0;
      rstN       = 1'b0;
      apply_reset();

      // reset state
      @(negedge clk);
      check("rst_tx_valid", txValid, 0);
      check("rst_src_ready", srcReady, 0);
      check("rst_grant", grantIdx, 0);
      check("rst_busy", busy, 0);
      check("rst_err", errProto, 0);
      check("rst_rr_ptr", rrPtr, 0);
      check("rst_stats", statsCount, 0);
      @(posedge clk);
      #1;

      // all three sources streaming 2-beat packets with txReady held high
      sopLog.delete();
      drive_pkts(2, 2, 2, 2, 2, 100, 0);
      expOrder = '{0, 1, 2, 0, 1, 2};
      check("rr_log_len", sopLog.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_order%0d", k), (k < sopLog.size()) ? sopLog[k] : -1, expOrder[k]);
      end

      // src1 mid-packet, src0 raises SOP and must wait for src1's EOP
      apply_reset();
      txReady = 1'b1;
      for (int b = 0; b < 4; b++) begin
         d[b] = {$urandom, $urandom};
         push_beat(1, d[b], b == 0, b == 3);
      end
      srcValid[1] = 1'b1;
      srcSOP[1]   = 1'b1;
      srcData[1]  = d[0];
      @(posedge clk);
      #1;
      srcData[0]  = {$urandom, $urandom};
      srcValid[0] = 1'b1;
      srcSOP[0]   = 1'b1;
      srcEOP[0]   = 1'b1;
      push_beat(0, srcData[0], 1'b1, 1'b1);
      for (int b = 1; b < 4; b++) begin
         srcSOP[1]  = 1'b0;
         srcEOP[1]  = (b == 3);
         srcData[1] = d[b];
         @(negedge clk);
         check("mid_src0_blocked", srcReady[0], 0);
         check("mid_src1_ready", srcReady[1], 1);
         @(posedge clk);
         #1;
      end
      srcValid[1] = 1'b0;
      srcEOP[1]   = 1'b0;
      @(negedge clk);
      check("mid_src0_granted", srcReady[0], 1);
      @(posedge clk);
      #1;
      idle_inputs();

      // txReady toggling during a 3-beat packet from src2
      apply_reset();
      for (int b = 0; b < 3; b++) begin
         d[b] = {$urandom, $urandom};
         push_beat(2, d[b], b == 0, b == 2);
      end
      pos = 0;
      for (int c = 0; c < 5; c++) begin
         srcValid[2] = (pos < 3);
         srcSOP[2]   = (pos == 0);
         srcEOP[2]   = (pos == 2);
         srcData[2]  = d[pos % 3];
         txReady     = (c % 2 == 0);
         @(negedge clk);
         check("toggle_busy", busy, (pos > 0) && (pos < 3));
         if (!txReady) check("toggle_no_valid", txValid, 0);
         acc = srcReady[2];
         @(posedge clk);
         #1;
         if (acc) pos++;
      end
      idle_inputs();
      check("toggle_beats", pos, 3);
      @(negedge clk);
      check("toggle_busy_end", busy, 0);
      @(posedge clk);
      #1;

      // single-beat packets: src2 then src0, pointer wraps 2 -> 0 then moves to 1
      apply_reset();
      one_beat(2, 1'b0);
      @(negedge clk);
      check("rr_after_src2", rrPtr, 0);
      check("idle_after_src2", arbState == S_PKT, 0);
      @(posedge clk);
      #1;
      one_beat(0, 1'b0);
      @(negedge clk);
      check("rr_after_src0", rrPtr, 1);
      check("idle_after_src0", arbState == S_PKT, 0);
      @(posedge clk);
      #1;

      // valid without SOP while idle
      apply_reset();
      txReady     = 1'b1;
      srcValid[1] = 1'b1;
      srcSOP[1]   = 1'b0;
      srcData[1]  = {$urandom, $urandom};
      @(negedge clk);
      check("bad_sop_not_ready", srcReady[1], 0);
      check("bad_sop_no_valid", txValid, 0);
      @(posedge clk);
      #1;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("err_sticky", errProto, 1);
      end
      @(posedge clk);
      #1 rstN = 1'b0;
      #1 check("err_cleared", errProto, 0);
      apply_reset();

      // reset in the middle of a packet drops the lock
      txReady = 1'b1;
      d[0] = {$urandom, $urandom};
      push_beat(2, d[0], 1'b1, 1'b0);
      srcValid[2] = 1'b1;
      srcSOP[2]   = 1'b1;
      srcData[2]  = d[0];
      @(negedge clk);
      check("pre_rst_ready", srcReady[2], 1);
      @(posedge clk);
      #1;
      srcSOP[2]  = 1'b0;
      srcData[2] = {$urandom, $urandom};
      check("pre_rst_busy", busy, 1);
      check("pre_rst_grant", grantIdx, 2);
      rstN = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_grant", grantIdx, 0);
      check("rst_mid_valid", txValid, 0);
      apply_reset();

      // packet counters: 5 from src0, 2 from src2, then a clear during an EOP
      drive_pkts(5, 0, 2, 1, 3, 80, 20);
      @(negedge clk);
      check("stats_src0", statsCount[0], expCnt(5));
      check("stats_src1", statsCount[1], 0);
      check("stats_src2", statsCount[2], expCnt(2));
      @(posedge clk);
      #1;
      one_beat(0, 1'b1);
      @(negedge clk);
      check("stats_clear0", statsCount[0], 0);
      check("stats_clear1", statsCount[1], 0);
      check("stats_clear2", statsCount[2], 0);
      @(posedge clk);
      #1;

      // randomized mix: variable lengths, gaps and backpressure
      apply_reset();
      drive_pkts(30, 30, 30, 1, 4, 70, 25);

      repeat (3) @(posedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      nFail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
